inv_rotate: RTL and testbench

- Inverse of the rho+pi step of the matrix encoder permutation, used by the decode path.
- Buffers one full 25x64 state, delivered slice by slice.
- Undoes the pi lane permutation and the rho per-lane rotation.
- Streams the restored state out slice by slice, in ascending z, to the next inverse stage.

---
 rtl/inv_rotate.sv | 129 ++++++++++++
 tb/tb_inv_rotate.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_rotate.sv
// inv_rotate: inverse of the rho+pi step of the matrix encoder permutation,
// used on the decode path.
//
// Collects one full 25x64 state, delivered one 25-bit slice per transfer
// in ascending z. It then streams the restored state out, again slice by
// slice in ascending z. Each restored lane is read from its pi source lane,
// with the rho rotation undone. The output is a pure mux on the buffer and
// ecnt, so there is no extra latency.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   in_slice   input slice, bit l = lane l = x+5*y
//   in_valid   in_slice valid
//   in_ready   block accepts a slice this cycle (high in LOAD)
//   out_slice  restored slice, bit l = lane x+5*y
//   out_valid  out_slice valid (high in EMIT)
//   out_ready  consumer accepts out_slice this cycle
//   out_z      slice index of out_slice
//   done       one-cycle pulse after the last output slice transfers
//
// state | meaning
// LOAD  | accepting input slices into the buffer, lcnt = next slice index
// EMIT  | presenting restored slice ecnt to the consumer

module inv_rotate (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] in_slice,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [24:0] out_slice,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_z,
  output logic        done
);

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  // Rho rotation amount of each lane l = x+5*y.
  localparam logic [5:0] ROT [25] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  // Pi source lane of output lane x+5*y: y + 5*((2x+3y) mod 5).
  localparam logic [4:0] PS [25] = '{
    5'd0,  5'd10, 5'd20, 5'd5,  5'd15,
    5'd16, 5'd1,  5'd11, 5'd21, 5'd6,
    5'd7,  5'd17, 5'd2,  5'd12, 5'd22,
    5'd23, 5'd8,  5'd18, 5'd3,  5'd13,
    5'd14, 5'd24, 5'd9,  5'd19, 5'd4
  };

  state_t      state, state_nxt;
  logic [5:0]  lcnt, lcnt_nxt;
  logic [5:0]  ecnt, ecnt_nxt;
  logic        done_nxt;
  logic        load_fire;
  logic [24:0] slice_buf [64];

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign out_z     = ecnt;
  assign load_fire = in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      lcnt  <= 6'd0;
      ecnt  <= 6'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
      ecnt  <= ecnt_nxt;
      done  <= done_nxt;
    end
  end

  // The buffer holds no reset value. Reset returns to LOAD, so the buffer
  // is always completely rewritten before EMIT reads it.
  always_ff @(posedge clk) begin
    if (load_fire && !rst) begin
      slice_buf[lcnt] <= in_slice;
    end
  end

  always_comb begin
    state_nxt = state;
    lcnt_nxt  = lcnt;
    ecnt_nxt  = ecnt;
    done_nxt  = 1'b0;
    case (state)
      LOAD: begin
        if (in_valid) begin
          // lcnt wraps from 63 to 0 on the final slice, ready for the next state.
          lcnt_nxt = lcnt + 6'd1;
          if (lcnt == 6'd63) begin
            state_nxt = EMIT;
            ecnt_nxt  = 6'd0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          ecnt_nxt = ecnt + 6'd1;
          if (ecnt == 6'd63) begin
            state_nxt = LOAD;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // Undoing a left rotation by R reads slice z+R. The 6-bit sum wraps mod 64.
  for (genvar l = 0; l < 25; l++) begin : g_lane
    assign out_slice[l] = slice_buf[ecnt + ROT[l]][PS[l]];
  end

endmodule

// File: tb/tb_inv_rotate.sv
// Self-checking bench for inv_rotate.
// A lane-level reference model is built from the Keccak rho offsets
// (triangular numbers along the (x,y) -> (y,2x+3y) walk) and the pi lane
// map. A negedge monitor compares every DUT output cycle against the model.
// Directed single-bit states pin the model with literal expectations.

module tb_inv_rotate;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] in_slice;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] out_slice;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_z;
  logic        done;

  inv_rotate dut (
    .clk       (clk),
    .rst       (rst),
    .in_slice  (in_slice),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_slice (out_slice),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rho [25];

  logic [24:0] tx_st   [64];
  logic [24:0] cap     [64];
  logic [24:0] cap_ref [64];
  logic [24:0] m_load  [64];
  logic [24:0] exp_st  [64];
  logic [24:0] tmp_st  [64];
  logic [63:0] a_l     [25];

  bit          exp_have   = 0;
  bit          exp_done   = 0;
  bit          just_reset = 0;
  bit          prev_stall = 0;
  logic [24:0] prev_slice;
  logic [5:0]  prev_z;
  int          m_lcnt     = 0;
  int          m_ez       = 0;
  int          done_cnt   = 0;
  int          states_m   = 0;
  bit          rt_phase   = 0;
  int          rt_cycles  = 0;
  int          stall_pct  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Inverse: output lane x+5y = source lane y+5*((2x+3y)%5), rotated right by rho.
  task automatic inv_model(input logic [24:0] s [64], output logic [24:0] o [64]);
    logic [63:0] b [25];
    logic [63:0] a;
    int l, src, r;
    for (int ln = 0; ln < 25; ln++)
      for (int z = 0; z < 64; z++) b[ln][z] = s[z][ln];
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        l   = x + 5 * y;
        src = y + 5 * ((2 * x + 3 * y) % 5);
        r   = rho[l];
        a   = (r == 0) ? b[src] : ((b[src] >> r) | (b[src] << (64 - r)));
        for (int z = 0; z < 64; z++) o[z][l] = a[z];
      end
    end
  endtask

  // Forward rho+pi, lane level: B[y, 2x+3y] = rotl(A[x,y], rho).
  task automatic fwd_model(input logic [63:0] a [25], output logic [24:0] s [64]);
    logic [63:0] b [25];
    int l, dst, r;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        l      = x + 5 * y;
        dst    = y + 5 * ((2 * x + 3 * y) % 5);
        r      = rho[l];
        b[dst] = (r == 0) ? a[l] : ((a[l] << r) | (a[l] >> (64 - r)));
      end
    end
    for (int z = 0; z < 64; z++)
      for (int ln = 0; ln < 25; ln++) s[z][ln] = b[ln][z];
  endtask

  // Compare process: checks every output cycle and tracks transfers.
  always @(negedge clk) begin
    bit in_x, out_x;
    if (rst) begin
      m_lcnt     = 0;
      m_ez       = 0;
      exp_have   = 0;
      exp_done   = 0;
      prev_stall = 0;
      just_reset = 1;
    end else begin
      if (just_reset) begin
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_done", done, 0);
        just_reset = 0;
      end
      check("done", done, exp_done);
      if (done) done_cnt++;
      check("out_valid", out_valid, exp_have);
      check("in_ready", in_ready, !exp_have);
      if (prev_stall) begin
        check("hold_slice", out_slice, prev_slice);
        check("hold_z", out_z, prev_z);
      end
      out_x    = out_valid && out_ready && exp_have;
      in_x     = in_valid && in_ready && !exp_have;
      exp_done = 0;
      if (out_x) begin
        check("out_z", out_z, m_ez);
        check("out_slice", out_slice, exp_st[m_ez]);
        cap[m_ez] = out_slice;
        if (m_ez == 63) begin
          m_ez     = 0;
          exp_have = 0;
          exp_done = 1;
          states_m++;
        end else begin
          m_ez++;
        end
      end
      if (in_x) begin
        m_load[m_lcnt] = in_slice;
        if (m_lcnt == 63) begin
          m_lcnt = 0;
          inv_model(m_load, exp_st);
          exp_have = 1;
        end else begin
          m_lcnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_slice = out_slice;
      prev_z     = out_z;
      if (rt_phase) rt_cycles++;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
    end
  end

  task automatic send_state(input int gap_pct, input int n);
    int guard;
    int gaps;
    for (int z = 0; z < n; z++) begin
      gaps = 0;
      while (gap_pct > 0 && gaps < 8 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        gaps++;
      end
      in_slice = tx_st[z];
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 1000) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: in_ready=%0b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 4000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("done_wait", done_cnt, target);
  endtask

  task automatic run_single(input string name, input int zi, input int bi,
                            input int zo, input int bo);
    int nz;
    int tgt;
    for (int z = 0; z < 64; z++) tx_st[z] = '0;
    tx_st[zi][bi] = 1'b1;
    tgt = done_cnt + 1;
    send_state(0, 64);
    wait_done(tgt);
    nz = 0;
    for (int z = 0; z < 64; z++) if (cap[z] != '0) nz++;
    check({name, "_slice"}, cap[zo], 64'(1) << bo);
    check({name, "_nonzero"}, nz, 1);
  endtask

  initial begin
    logic [24:0] acc;
    int x, y, nx, tgt, bad;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_slice = '0;

    rho[0] = 0;
    x = 1;
    y = 0;
    for (int t = 0; t < 24; t++) begin
      rho[x + 5 * y] = ((t + 1) * (t + 2) / 2) % 64;
      nx = y;
      y  = (2 * x + 3 * y) % 5;
      x  = nx;
    end
    check("rho_lane2", rho[2], 62);
    check("rho_lane24", rho[24], 14);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // All-zero state.
    for (int z = 0; z < 64; z++) tx_st[z] = '0;
    tgt = done_cnt + 1;
    send_state(0, 64);
    wait_done(tgt);
    acc = '0;
    for (int z = 0; z < 64; z++) acc |= cap[z];
    check("zero_state", acc, 0);

    // Single-bit states. Input bit (slice zi, lane ps(l)) lands in output
    // slice (zi - R[l]) mod 64, lane l.
    run_single("lane0", 1, 0, 1, 0);      // lane 0: R=0,  ps=0
    run_single("lane1", 5, 10, 4, 1);     // lane 1: R=1,  ps=10
    run_single("lane2_wrap", 0, 20, 2, 2); // lane 2: R=62, ps=20, 2+62=64 wraps to 0
    run_single("lane12", 5, 2, 26, 12);   // lane 12: R=43, ps=2, 26+43 = 69 mod 64 = 5

    // Backpressure: the same random state without and then with stalls.
    for (int z = 0; z < 64; z++) tx_st[z] = 25'($urandom);
    tgt = done_cnt + 1;
    send_state(0, 64);
    wait_done(tgt);
    for (int z = 0; z < 64; z++) cap_ref[z] = cap[z];
    stall_pct = 40;
    tgt = done_cnt + 1;
    send_state(30, 64);
    wait_done(tgt);
    stall_pct = 0;
    bad = 0;
    for (int z = 0; z < 64; z++) if (cap[z] !== cap_ref[z]) bad++;
    check("stall_vs_nostall", bad, 0);

    // Round trip: 20 random states, back to back.
    @(posedge clk);
    #1;
    rt_cycles = 0;
    rt_phase  = 1;
    tgt = done_cnt + 20;
    for (int k = 0; k < 20; k++) begin
      for (int l = 0; l < 25; l++) a_l[l] = {$urandom, $urandom};
      fwd_model(a_l, tx_st);
      inv_model(tx_st, tmp_st);
      bad = 0;
      for (int z = 0; z < 64; z++)
        for (int l = 0; l < 25; l++)
          if (tmp_st[z][l] !== a_l[l][z]) bad++;
      check("rt_model", bad, 0);
      send_state(0, 64);
    end
    wait_done(tgt);
    rt_phase = 0;
    // 20 states of 64 loads plus 64 emits with no bubble, then the final done cycle.
    check("rt_cycles", rt_cycles, 20 * 128 + 1);

    // Reset while slice 30 is being loaded: no done, next state still correct.
    for (int z = 0; z < 64; z++) tx_st[z] = 25'($urandom);
    send_state(0, 30);
    in_slice = tx_st[30];
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    tgt = done_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt, tgt);
    for (int z = 0; z < 64; z++) tx_st[z] = 25'($urandom);
    tgt = done_cnt + 1;
    send_state(10, 64);
    wait_done(tgt);

    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, states_m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
